// File: rtl/ps2_scancode_rx_pkg.sv
// Shared PS/2 definitions: frame geometry, receiver state encoding and the
// scancode constants used by the receiver and the downstream keyboard decoder.
package ps2_pkg;

    localparam int         PS2_FRAME_BITS = 11;
    localparam int         PS2_SHIFT_BITS = PS2_FRAME_BITS - 1;
    localparam logic [3:0] PS2_LAST_BIT   = 4'(PS2_SHIFT_BITS - 1);
    localparam logic [3:0] PS2_BITCNT_MAX = 4'(PS2_SHIFT_BITS);

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // Scancodes (set 2) referenced by the keyboard command decoder
    localparam logic [7:0] PS2_KEY_F1    = 8'h05;
    localparam logic [7:0] PS2_KEY_F2    = 8'h06;
    localparam logic [7:0] PS2_KEY_A     = 8'h1C;
    localparam logic [7:0] PS2_KEY_SPACE = 8'h29;
    localparam logic [7:0] PS2_KEY_ENTER = 8'h5A;
    localparam logic [7:0] PS2_KEY_ESC   = 8'h76;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ps2_state_t;

    // frame = {stop, parity, data[7:0]} with the start bit already stripped
    function automatic logic ps2_frame_ok(input logic [9:0] frame);
        return ((^frame[7:0]) ^ frame[8]) & frame[9];
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a level filter: the output level only
// follows the input once it has held a new value for FILTER_LEN cycles.
// A one-cycle fall pulse accompanies every filtered 1->0 transition.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int             CW       = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous line into the CLK domain (idle level is high)
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= line_in;
            sync_q2 <= sync_q1;
        end
    end

    // Count consecutive cycles of disagreement; any agreement restarts the run
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_q2;
                cnt   <= '0;
                fall  <= ~sync_q2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, checks odd parity and
// the stop bit, and presents the last two good bytes as {previous, newest}.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    output logic [15:0] KBBuffer,
    output logic        Key_Strobe,
    output logic        Frame_Err,
    output logic        Busy
);

    localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    logic          clk_level;
    logic          clk_fall;
    logic          data_q1;
    logic          data_q2;
    logic          sample;

    ps2_state_t    state,  state_nxt;
    logic [3:0]    bitcnt, bitcnt_nxt;
    logic [9:0]    shreg,  shreg_nxt;
    logic [TW-1:0] timer,  timer_nxt;
    logic [15:0]   kbbuf_nxt;
    logic          strobe_nxt;
    logic          err_nxt;
    logic [9:0]    frame;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .line_in (PS2_CLK),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    // Data line only needs synchronising; it is stable long before each clock fall
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            data_q1 <= 1'b1;
            data_q2 <= 1'b1;
        end else begin
            data_q1 <= PS2_DATA;
            data_q2 <= data_q1;
        end
    end

    // A fall pulse always coincides with the filtered level going low
    assign sample = clk_fall & ~clk_level;
    // Frame as it will look once the current bit is shifted in (LSB first)
    assign frame  = {data_q2, shreg[9:1]};
    assign Busy   = (state == SHIFT);

    // Receiver registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            timer      <= '0;
            KBBuffer   <= '0;
            Key_Strobe <= 1'b0;
            Frame_Err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bitcnt     <= bitcnt_nxt;
            shreg      <= shreg_nxt;
            timer      <= timer_nxt;
            KBBuffer   <= kbbuf_nxt;
            Key_Strobe <= strobe_nxt;
            Frame_Err  <= err_nxt;
        end
    end

    // Next-state, shift, timeout and result evaluation
    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        timer_nxt  = timer;
        kbbuf_nxt  = KBBuffer;
        strobe_nxt = 1'b0;
        err_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                timer_nxt = '0;
                if (sample && !data_q2) begin
                    state_nxt  = SHIFT;
                    bitcnt_nxt = '0;
                end
            end
            SHIFT: begin
                // A fall beats a coincident timeout: the bit is taken
                if (sample) begin
                    shreg_nxt  = frame;
                    timer_nxt  = '0;
                    bitcnt_nxt = (bitcnt == PS2_BITCNT_MAX) ? PS2_BITCNT_MAX : bitcnt + 4'd1;
                    if (bitcnt == PS2_LAST_BIT) begin
                        state_nxt = IDLE;
                        if (ps2_frame_ok(frame)) begin
                            kbbuf_nxt  = {KBBuffer[7:0], frame[7:0]};
                            strobe_nxt = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end else if (timer == TIMER_LAST) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                    err_nxt   = 1'b1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed and randomized frames against a byte-level model of the receiver.
module tb_ps2_scancode_rx;

    localparam int BIT_HALF = 200;

    logic        CLK;
    logic        RESET_N;
    logic        PS2_CLK;
    logic        PS2_DATA;
    logic [15:0] KBBuffer;
    logic        Key_Strobe;
    logic        Frame_Err;
    logic        Busy;

    int vectors     = 0;
    int miscompares = 0;

    int strobe_cnt = 0;
    int err_cnt    = 0;
    int both_cnt   = 0;
    int busy_cyc   = 0;

    logic [15:0] exp_kb      = 16'h0000;
    int          exp_strobes = 0;
    int          exp_errs    = 0;

    ps2_scancode_rx #(
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (2000)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .PS2_CLK    (PS2_CLK),
        .PS2_DATA   (PS2_DATA),
        .KBBuffer   (KBBuffer),
        .Key_Strobe (Key_Strobe),
        .Frame_Err  (Frame_Err),
        .Busy       (Busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (Key_Strobe) strobe_cnt <= strobe_cnt + 1;
        if (Frame_Err) err_cnt <= err_cnt + 1;
        if (Key_Strobe && Frame_Err) both_cnt <= both_cnt + 1;
        if (Busy) busy_cyc <= busy_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the first nbits of a device-to-host frame; optional short low
    // glitch in the high phase of bit glitch_bit
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = f[i];
            if (i == glitch_bit) begin
                repeat (BIT_HALF / 2) @(negedge CLK);
                PS2_CLK = 1'b0;
                repeat (5) @(negedge CLK);
                PS2_CLK = 1'b1;
                repeat (BIT_HALF / 2 - 5) @(negedge CLK);
            end else begin
                repeat (BIT_HALF) @(negedge CLK);
            end
            PS2_CLK = 1'b0;
            repeat (BIT_HALF) @(negedge CLK);
            PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
        repeat (60) @(negedge CLK);
    endtask

    // Byte-level model: good frame shifts into the two-byte window, bad one errors
    task automatic model_frame(input logic [7:0] b, input logic par, input logic stop);
        int ones;
        ones = 0;
        for (int k = 0; k < 8; k++) ones += int'(b[k]);
        if ((((ones + int'(par)) % 2) == 1) && stop) begin
            exp_kb = {exp_kb[7:0], b};
            exp_strobes++;
        end else begin
            exp_errs++;
        end
    endtask

    task automatic full_frame(input string tag, input logic [7:0] b, input logic par,
                              input logic stop, input int glitch_bit);
        send_frame(b, par, stop, 11, glitch_bit);
        model_frame(b, par, stop);
        check({tag, "_kb"}, 32'(KBBuffer), 32'(exp_kb));
        check({tag, "_strobes"}, strobe_cnt, exp_strobes);
        check({tag, "_errs"}, err_cnt, exp_errs);
    endtask

    function automatic logic good_par(input logic [7:0] b);
        return ~(^b);
    endfunction

    initial begin
        int          busy0;
        logic [7:0]  rb;
        int          r;

        RESET_N  = 1'b0;
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        repeat (5) @(negedge CLK);
        check("rst_kb", 32'(KBBuffer), 32'h0);
        check("rst_strobe", 32'(Key_Strobe), 32'h0);
        check("rst_err", 32'(Frame_Err), 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        RESET_N = 1'b1;
        repeat (10) @(negedge CLK);

        // Single make code, then a release sequence
        busy0 = busy_cyc;
        full_frame("f05", 8'h05, 1'b1, 1'b1, -1);
        check("f05_busy_cycles", busy_cyc - busy0, 4000);
        check("f05_busy_after", 32'(Busy), 32'h0);
        full_frame("fF0", 8'hF0, 1'b1, 1'b1, -1);
        full_frame("f05b", 8'h05, 1'b1, 1'b1, -1);

        // Parity error leaves the window untouched; next good byte shifts in
        full_frame("par_err", 8'h05, 1'b0, 1'b1, -1);
        full_frame("f1C", 8'h1C, 1'b0, 1'b1, -1);

        // Partial frame followed by silence longer than the timeout
        send_frame(8'h3C, 1'b1, 1'b1, 5, -1);
        check("partial_busy", 32'(Busy), 32'h1);
        repeat (2500) @(negedge CLK);
        exp_errs++;
        check("timeout_errs", err_cnt, exp_errs);
        check("timeout_busy", 32'(Busy), 32'h0);
        check("timeout_strobes", strobe_cnt, exp_strobes);
        full_frame("f5A", 8'h5A, 1'b1, 1'b1, -1);
        full_frame("f5A_repeat", 8'h5A, 1'b1, 1'b1, -1);

        // Short glitches on the clock line are ignored
        PS2_CLK = 1'b0;
        repeat (3) @(negedge CLK);
        PS2_CLK = 1'b1;
        repeat (50) @(negedge CLK);
        check("idle_glitch_busy", 32'(Busy), 32'h0);
        busy0 = busy_cyc;
        full_frame("glitch29", 8'h29, good_par(8'h29), 1'b1, 4);
        check("glitch_busy_cycles", busy_cyc - busy0, 4000);

        // Reset in the middle of a frame
        send_frame(8'h33, 1'b1, 1'b1, 7, -1);
        PS2_DATA = 1'b0;
        repeat (BIT_HALF) @(negedge CLK);
        PS2_CLK = 1'b0;
        repeat (BIT_HALF / 2) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check("midrst_kb", 32'(KBBuffer), 32'h0);
        check("midrst_busy", 32'(Busy), 32'h0);
        check("midrst_strobe", 32'(Key_Strobe), 32'h0);
        check("midrst_err", 32'(Frame_Err), 32'h0);
        exp_kb = 16'h0000;
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        repeat (5) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (20) @(negedge CLK);
        check("midrst_strobes", strobe_cnt, exp_strobes);
        check("midrst_errs", err_cnt, exp_errs);
        full_frame("f76", 8'h76, 1'b0, 1'b1, -1);

        // Random bytes, occasionally with a bad parity or stop bit
        for (int n = 0; n < 3; n++) begin
            rb = 8'($urandom_range(0, 255));
            r  = int'($urandom_range(0, 5));
            full_frame("rand", rb, good_par(rb) ^ (r == 0), (r != 1), -1);
        end

        check("never_both", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
